// File: rtl/poly_intp_pkg.sv
// Shared types, sizing helpers and output rounding for the polyphase interpolator.
package poly_intp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_RND  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Coefficient bank depth for a given taps-per-phase and maximum rate.
  function automatic int unsigned ncoef_f(input int unsigned tpp, input int unsigned max_rate);
    return tpp * max_rate;
  endfunction

  // Accumulator width wide enough that TPP full-scale products never overflow.
  function automatic int unsigned acc_w_f(input int unsigned width, input int unsigned coef_w,
                                          input int unsigned tpp);
    return width + coef_w + $clog2(tpp) + 1;
  endfunction

  localparam int unsigned NCOEF = ncoef_f(4, 8);
  localparam int unsigned ACC_W = acc_w_f(16, 16, 4);

  // Round half up, arithmetic shift, then clamp to a signed width-bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int unsigned shift,
                                                   input int unsigned width);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    r  = r >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/poly_intp_mc_lane.sv
// One channel: delay line, shared multiplier, accumulator and rounded output register.
module poly_mac_lane
  import poly_intp_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TPP    = 4,
  parameter int unsigned SHIFT  = 15,
  parameter int unsigned ACC_W  = 35,
  parameter int unsigned JW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en_i,
  input  logic                     clr_i,
  input  logic                     mac_en_i,
  input  logic                     rnd_en_i,
  input  logic [JW-1:0]            j_i,
  input  logic signed [WIDTH-1:0]  din_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [WIDTH-1:0]  dout_o
);

  localparam int unsigned PW = WIDTH + COEF_W;

  logic signed [WIDTH-1:0] sr_q [TPP];
  logic signed [ACC_W-1:0] acc_q;
  logic signed [WIDTH-1:0] dout_q;
  logic signed [PW-1:0]    prod_c;

  assign prod_c = PW'(sr_q[j_i]) * PW'(coef_i);
  assign dout_o = dout_q;

  // Delay line: newest sample enters at tap 0, oldest falls off the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TPP; i++) sr_q[i] <= '0;
    end else if (shift_en_i) begin
      sr_q[0] <= din_i;
      for (int i = 1; i < TPP; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  // Multiply-accumulate, cleared at the start of every phase.
  always_ff @(posedge clk) begin
    if (rst || clr_i) acc_q <= '0;
    else if (mac_en_i) acc_q <= acc_q + ACC_W'(prod_c);
  end

  // Rounded and saturated result, held until the next phase completes.
  always_ff @(posedge clk) begin
    if (rst) dout_q <= '0;
    else if (rnd_en_i) dout_q <= WIDTH'(round_sat(64'(acc_q), SHIFT, WIDTH));
  end

endmodule

// File: rtl/poly_intp_mc.sv
// Multi-channel polyphase interpolator: shared control FSM, coefficient bank, handshakes.
module poly_intp_mc
  import poly_intp_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned CH       = 2,
  parameter int unsigned MAX_RATE = 8,
  parameter int unsigned TPP      = 4,
  parameter int unsigned SHIFT    = 15
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [CH*WIDTH-1:0]                   in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CH*WIDTH-1:0]                   out_data,
  output logic [$clog2(MAX_RATE)-1:0]           out_phase,
  input  logic [$clog2(MAX_RATE):0]             cfg_rate,
  input  logic                                  coef_we,
  input  logic [$clog2(TPP*MAX_RATE)-1:0]       coef_addr,
  input  logic [COEF_W-1:0]                     coef_data,
  output logic                                  busy
);

  localparam int unsigned PHW    = $clog2(MAX_RATE);
  localparam int unsigned NC     = ncoef_f(TPP, MAX_RATE);
  localparam int unsigned AW     = $clog2(NC);
  localparam int unsigned ACC_WL = acc_w_f(WIDTH, COEF_W, TPP);
  localparam int unsigned JW     = (TPP > 1) ? $clog2(TPP) : 1;

  state_e            state_q, state_d;
  logic [PHW:0]      rate_q, rate_d;
  logic [PHW-1:0]    p_q, p_d;
  logic [JW-1:0]     j_q, j_d;
  logic              out_valid_q, out_valid_d;
  logic [PHW-1:0]    out_phase_q, out_phase_d;
  logic              busy_q;
  logic              in_rdy_q;
  logic [COEF_W-1:0] coef_q [NC];
  logic [COEF_W-1:0] coef_sel_c;
  logic              shift_en_c, clr_c, mac_en_c, rnd_en_c;

  assign in_ready   = in_rdy_q & ~rst;
  assign out_valid  = out_valid_q;
  assign out_phase  = out_phase_q;
  assign busy       = busy_q;
  assign coef_sel_c = coef_q[AW'(32'(j_q) * 32'(rate_q) + 32'(p_q))];

  // Next-state, counter updates and lane control strobes.
  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    p_d         = p_q;
    j_d         = j_q;
    out_valid_d = out_valid_q;
    out_phase_d = out_phase_q;
    shift_en_c  = 1'b0;
    clr_c       = 1'b0;
    mac_en_c    = 1'b0;
    rnd_en_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          shift_en_c = 1'b1;
          clr_c      = 1'b1;
          if (cfg_rate == '0) rate_d = (PHW+1)'(1);
          else if (32'(cfg_rate) > MAX_RATE) rate_d = (PHW+1)'(MAX_RATE);
          else rate_d = cfg_rate;
          p_d     = '0;
          j_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en_c = 1'b1;
        if (j_q == JW'(TPP - 1)) state_d = ST_RND;
        else j_d = j_q + JW'(1);
      end
      ST_RND: begin
        rnd_en_c    = 1'b1;
        out_phase_d = p_q;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if ((32'(p_q) + 32'd1) < 32'(rate_q)) begin
            p_d     = p_q + PHW'(1);
            j_d     = '0;
            clr_c   = 1'b1;
            state_d = ST_MAC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rate_q      <= (PHW+1)'(1);
      p_q         <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
      out_phase_q <= '0;
      busy_q      <= 1'b0;
      in_rdy_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      p_q         <= p_d;
      j_q         <= j_d;
      out_valid_q <= out_valid_d;
      out_phase_q <= out_phase_d;
      busy_q      <= (state_d != ST_IDLE);
      in_rdy_q    <= (state_d == ST_IDLE);
    end
  end

  // Coefficient bank: writable only while idle and in range.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NC; k++) coef_q[k] <= '0;
    end else if (coef_we && !busy_q && (32'(coef_addr) < NC)) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // One arithmetic lane per channel, all sequenced by the shared FSM.
  for (genvar c = 0; c < CH; c++) begin : g_lane
    poly_mac_lane #(
      .WIDTH (WIDTH),
      .COEF_W(COEF_W),
      .TPP   (TPP),
      .SHIFT (SHIFT),
      .ACC_W (ACC_WL),
      .JW    (JW)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .shift_en_i(shift_en_c),
      .clr_i     (clr_c),
      .mac_en_i  (mac_en_c),
      .rnd_en_i  (rnd_en_c),
      .j_i       (j_q),
      .din_i     (in_data[c*WIDTH +: WIDTH]),
      .coef_i    (coef_sel_c),
      .dout_o    (out_data[c*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_poly_intp_mc.sv
// Directed bench: three instances (SHIFT 0, 1, 15) run in lockstep on shared stimulus.
module tb_poly_intp_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        coef_we = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  cfg_rate = 4'd4;
  logic [4:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic [2:0]  ir, ov, by;
  logic [31:0] od [3];
  logic [2:0]  oph [3];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  poly_intp_mc #(.SHIFT(0)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_phase(oph[0]),
    .cfg_rate(cfg_rate), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(by[0]));

  poly_intp_mc #(.SHIFT(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_phase(oph[1]),
    .cfg_rate(cfg_rate), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(by[1]));

  poly_intp_mc #(.SHIFT(15)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_phase(oph[2]),
    .cfg_rate(cfg_rate), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(by[2]));

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wcoef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = 5'(a);
    coef_data = 16'(d);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input int s0, input int s1);
    int n = 0;
    in_valid = 1'b1;
    in_data  = {16'(s1), 16'(s0)};
    while (ir[0] !== 1'b1 && n < 100) begin tick(); n++; end
    check("accept_ready", 32'(ir[0]), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get(input int inst, input int e0, input int e1, input int eph,
                     input bit chk, input int hold, input string tag);
    int n = 0;
    logic [31:0] snap_d;
    logic [2:0]  snap_p;
    while (ov[0] !== 1'b1 && n < 100) begin tick(); n++; end
    check({tag, "_valid"}, 32'(ov[inst]), 1);
    if (chk) begin
      check({tag, "_ch0"}, 32'($signed(od[inst][15:0])), e0);
      check({tag, "_ch1"}, 32'($signed(od[inst][31:16])), e1);
      check({tag, "_phase"}, 32'(oph[inst]), eph);
    end
    if (hold > 0) begin
      out_ready = 1'b0;
      snap_d = od[inst];
      snap_p = oph[inst];
      for (int i = 0; i < hold; i++) begin
        tick();
        check({tag, "_hold_data"}, od[inst], snap_d);
        check({tag, "_hold_phase"}, 32'(oph[inst]), 32'(snap_p));
      end
      check({tag, "_hold_valid"}, 32'(ov[inst]), 1);
      check({tag, "_hold_in_ready"}, 32'(ir[inst]), 0);
      out_ready = 1'b1;
    end
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_in_ready", 32'(ir[0]), 0);
    check("rst_out_valid", 32'(ov[0]), 0);
    check("rst_busy", 32'(by[0]), 0);
    check("rst_out_data", od[0], 0);
    check("rst_out_phase", 32'(oph[0]), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(ir[0]), 1);

    // Impulse response, rate 4, coef[k] = k+1, with backpressure at burst 1 phase 2
    cfg_rate = 4'd4;
    for (int k = 0; k < 16; k++) wcoef(k, k + 1);
    for (int b = 0; b < 4; b++) begin
      send((b == 0) ? 1 : 0, 0);
      if (b == 0) begin
        repeat (4) tick();
        check("latency_not_yet", 32'(ov[0]), 0);
        tick();
        check("latency_valid", 32'(ov[0]), 1);
      end
      for (int p = 0; p < 4; p++)
        get(0, b * 4 + p + 1, 0, p, 1'b1, (b == 1 && p == 2) ? 10 : 0, "impulse");
    end
    check("impulse_end_in_ready", 32'(ir[0]), 1);

    // Round half up at SHIFT=1
    cfg_rate = 4'd1;
    wcoef(0, 1);
    for (int k = 1; k < 4; k++) wcoef(k, 0);
    send(3, 5);
    get(1, 2, 3, 0, 1'b1, 0, "round_pos");
    send(-3, -5);
    get(1, -1, -2, 0, 1'b1, 0, "round_neg");

    // Positive saturation at SHIFT=15 with full-scale coefficients and samples
    for (int k = 0; k < 4; k++) wcoef(k, 16'h7FFF);
    for (int i = 0; i < 4; i++) begin
      send(16'h7FFF, 16'h7FFF);
      get(2, 32767, 32767, 0, i == 3, 0, "sat_max");
    end
    for (int k = 0; k < 4; k++) wcoef(k, 16'h8000);
    for (int i = 0; i < 4; i++) begin
      send(-32768, -32768);
      get(2, 32767, 32767, 0, i == 3, 0, "sat_minmin");
    end
    // Negative saturation at SHIFT=0
    for (int k = 0; k < 4; k++) wcoef(k, 16'h7FFF);
    send(-32768, -32768);
    get(0, -32768, -32768, 0, 1'b1, 0, "sat_neg");

    // Rate clamp, latch and busy write protection
    for (int k = 0; k < 32; k++) wcoef(k, 0);
    cfg_rate = 4'd0;
    send(1, 1);
    get(0, 0, 0, 0, 1'b1, 0, "rate0");
    check("rate0_done_in_ready", 32'(ir[0]), 1);
    check("rate0_done_valid", 32'(ov[0]), 0);
    cfg_rate = 4'd9;
    send(7, 7);
    wcoef(0, 100);
    cfg_rate = 4'd2;
    for (int p = 0; p < 8; p++) get(0, 0, 0, p, 1'b1, 0, "rate9");
    check("rate9_done_in_ready", 32'(ir[0]), 1);
    send(1, 1);
    for (int p = 0; p < 2; p++) get(0, 0, 0, p, 1'b1, 0, "rate2_busywr");
    check("rate2_done_in_ready", 32'(ir[0]), 1);

    // Reset during MAC
    cfg_rate = 4'd1;
    send(5, 0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(ir[0]), 0);
    check("midrst_out_valid", 32'(ov[0]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("after_rst_in_ready", 32'(ir[0]), 1);
    check("after_rst_busy", 32'(by[0]), 0);
    tick();
    check("after_rst_no_stale_valid", 32'(ov[0]), 0);
    wcoef(0, 2);
    send(5, 0);
    get(0, 10, 0, 0, 1'b1, 0, "after_rst_out");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_intp_mc.md
# poly_intp_mc

Multi-channel polyphase interpolator that upsamples CH parallel sample streams by a runtime-selectable factor of 1..MAX_RATE. It uses one time-shared multiplier per channel, a coefficient bank writable at runtime, round-half-up plus saturation, and valid/ready handshakes on both sides. It sits in the DSP chain between a decimated baseband source and the DAC-rate datapath, and supersedes the fixed-rate, single-channel, purely combinational interpolator.

## Interface
- WIDTH, 16: sample width (signed, in and out).
- COEF_W, 16: coefficient width (signed).
- CH, 2: channel count.
- MAX_RATE, 8: maximum interpolation factor.
- TPP, 4: taps per phase. The bank holds NCOEF = TPP*MAX_RATE coefficients.
- SHIFT, 15: arithmetic right shift applied to the accumulator before saturation. SHIFT >= 0.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input sample set valid.
- in_ready  out  1  block can accept an input sample set.
- in_data  in  CH×WIDTH  one signed sample per channel.
- out_valid  out  1  output sample set valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  CH×WIDTH  one interpolated sample per channel.
- out_phase  out  clog2(MAX_RATE)  phase index p of the current output.
- cfg_rate  in  clog2(MAX_RATE)+1  requested interpolation factor.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(NCOEF)  coefficient index k.
- coef_data  in  COEF_W  coefficient value.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, MAC, RND, OUT.
- IDLE:
  - in_ready=1 (0 while rst is high).
  - On in_valid&in_ready: each channel's delay line shifts, with sr[0]=new sample and sr[TPP-1] dropped.
  - rate is latched from cfg_rate. A value of 0 is treated as 1; a value above MAX_RATE is clamped to MAX_RATE.
  - p=0, j=0, acc=0, then go to MAC.
- MAC:
  - Each cycle, acc += sr[j]*coef[j*rate+p] for every channel, then j++.
  - After j=TPP-1, go to RND.
- RND:
  - Per channel, y = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT.
  - y is saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and registered into out_data.
  - out_phase is set to p and out_valid=1. Go to OUT.
- OUT:
  - out_data and out_phase are held stable while out_valid&!out_ready.
  - On handshake with p<rate-1: out_valid=0, p++, j=0, acc=0, go to MAC.
  - On handshake with p=rate-1: out_valid=0, go to IDLE.
- Accumulator width ACC_W = WIDTH+COEF_W+clog2(TPP)+1. The accumulator does not overflow internally.
- Coefficient writes:
  - Accepted only when busy=0. Writes while busy=1 are ignored.
  - A write with coef_addr >= NCOEF is ignored.
- Delay lines persist across bursts and are cleared only by rst.
- Channels share the FSM and are arithmetically independent.

## Timing
- Reset (sync): state=IDLE, out_valid=0, out_data=0, out_phase=0, busy=0, delay lines=0, acc=0, coefficients=0. in_ready=0 during the rst cycle and 1 on the first cycle after it.
- rst mid-operation aborts the burst at the next edge. The partial output is discarded, not presented.
- Latency: with the accept at edge E0, out_valid is first high after edge E(TPP+1).
- Phase throughput: TPP+2 cycles per output while out_ready=1. One input is accepted every rate*(TPP+2)+1 cycles.
- in_ready returns high on the cycle after the last-phase output handshake. There is no input/output overlap.
- cfg_rate changes are ignored until the next input accept.
- A coefficient write in the same cycle as an input accept takes effect for that burst, since busy is still 0.

## Structure
- Package poly_intp_pkg holds:
  - the FSM state enum;
  - the localparams NCOEF and ACC_W, as functions of the parameters;
  - a function round_sat(acc, SHIFT, WIDTH).
- Sub-module poly_mac_lane: one per channel via generate. Each lane contains its delay line, multiplier, accumulator and round_sat output register. It is driven by shift_en, clr, mac_en, j and coefficient from the top.
- The top holds the FSM, the rate/p/j counters, the coefficient register bank and the handshakes.

## Test plan
- Impulse response:
  - Setup: rate=4, TPP=4, SHIFT=0, coef[k]=k+1.
  - Stimulus: ch0 input 1 followed by three 0s.
  - Required response: 16 ch0 outputs reading 1,2,…,16, with out_phase cycling 0..3.
- Rounding and saturation:
  - Setup: SHIFT=1, coef0=1, sample 3. Required output: 2. Sample -3: required output -1.
  - Setup: SHIFT=15, all coefs 0x7FFF, rate=1, four inputs of 0x7FFF. Required output: 0x7FFF.
  - Four inputs of 0x8000 with all coefs 0x8000. Required output: 0x7FFF (saturated).
- Backpressure:
  - Stimulus: out_ready held low 10 cycles at phase 2.
  - Required response: out_data and out_phase stable, in_ready=0, then phase 3 follows with no loss or duplication.
- Rate clamp and latch:
  - cfg_rate=0 gives 1 output per input. cfg_rate=9 with MAX_RATE=8 gives 8.
  - A cfg_rate change mid-burst takes effect only on the next accept.
  - A coef write while busy leaves the bank unchanged.
- Reset mid-MAC:
  - Stimulus: rst for one cycle in MAC.
  - Required response: out_valid=0 and in_ready=0 during rst, in_ready=1 after.
  - After reloading coef0=2, SHIFT=0, input 5: first output is 10.
- Channel independence:
  - Stimulus: ch0 impulse with ch1 all zeros.
  - Required response: ch1 outputs all 0 and ch0 matches the impulse response.
